// File: rtl/apb_payload_pkg.sv
// Shared types and widths for the APB payload writer.
package apb_payload_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned SIZE_W     = 5;
   localparam int unsigned ADDR_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } wr_state_e;

   // Payload register set captured when a burst is accepted.
   typedef struct packed {
      logic [DATA_W-1:0] p0;
      logic [DATA_W-1:0] p1;
      logic [SIZE_W-1:0] size;
   } payload_t;

endpackage

// File: rtl/apb_wr_timer.sv
// ACCESS-phase watchdog: counts enabled cycles, flags the last allowed one.
// Only instantiated when APB_WR_TIMEOUT_EN is defined.
module apb_wr_timer #(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic pclk,
   input  logic preset_n,
   input  logic enable,
   input  logic clear,
   output logic expired_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // High during the TIMEOUT_CYC-th enabled cycle.
   assign expired_c = enable && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_payload_writer.sv
// APB write sequencer: streams the latched payload bytes as single-byte APB writes.
// Optional ACCESS-phase timeout is enabled by defining APB_WR_TIMEOUT_EN.
module apb_payload_writer
   import apb_payload_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned BASE_ADDR    = 0,
   parameter int unsigned ADDR_STEP    = 1,
   parameter bit          ABORT_ON_ERR = 1'b1,
   parameter int unsigned TIMEOUT_CYC  = 16
) (
   input  logic              pclk,
   input  logic              preset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] payload_0,
   input  logic [DATA_W-1:0] payload_1,
   input  logic [SIZE_W-1:0] data_size,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              timeout,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic              pslverr
);

   wr_state_e         state_q, state_nxt;
   payload_t          pl_q, pl_nxt;
   logic [SIZE_W-1:0] idx_q, idx_nxt;
   logic [ADDR_W-1:0] paddr_nxt;
   logic [DATA_W-1:0] pwdata_nxt;
   logic              err_nxt;
   logic              tmo_q, tmo_nxt;
   logic              psel_nxt, penable_nxt, busy_nxt, done_nxt;
   logic              timer_expired;

`ifdef APB_WR_TIMEOUT_EN
   apb_wr_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .pclk      (pclk),
      .preset_n  (preset_n),
      .enable    (state_q == ACCESS),
      .clear     (state_q != ACCESS),
      .expired_c (timer_expired)
   );
`else
   // ACCESS waits on pready indefinitely in this build.
   assign timer_expired = 1'b0;
   if (TIMEOUT_CYC == 0) begin : g_timeout_unused
   end
`endif

   // State, datapath and registered outputs.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q <= IDLE;
         pl_q    <= '0;
         idx_q   <= '0;
         paddr   <= '0;
         pwdata  <= '0;
         psel    <= 1'b0;
         penable <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         pl_q    <= pl_nxt;
         idx_q   <= idx_nxt;
         paddr   <= paddr_nxt;
         pwdata  <= pwdata_nxt;
         psel    <= psel_nxt;
         penable <= penable_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
         tmo_q   <= tmo_nxt;
      end
   end

   // Next-state and next-output logic; outputs follow the state being entered.
   always_comb begin
      state_nxt  = state_q;
      pl_nxt     = pl_q;
      idx_nxt    = idx_q;
      paddr_nxt  = paddr;
      pwdata_nxt = pwdata;
      err_nxt    = err;
      tmo_nxt    = tmo_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               pl_nxt.p0   = payload_0;
               pl_nxt.p1   = payload_1;
               pl_nxt.size = data_size;
               idx_nxt     = '0;
               err_nxt     = 1'b0;
               tmo_nxt     = 1'b0;
               paddr_nxt   = ADDR_W'(BASE_ADDR);
               pwdata_nxt  = payload_0;
               state_nxt   = (data_size == '0) ? DONE : SETUP;
            end
         end
         SETUP: begin
            state_nxt = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               if (pslverr) begin
                  err_nxt = 1'b1;
               end
               if (pslverr && ABORT_ON_ERR) begin
                  state_nxt = DONE;
               end else if (idx_q == SIZE_W'(pl_q.size - SIZE_W'(1))) begin
                  state_nxt = DONE;
               end else begin
                  // Next byte index flips parity, so pick the other payload.
                  idx_nxt    = idx_q + SIZE_W'(1);
                  paddr_nxt  = paddr + ADDR_W'(ADDR_STEP);
                  pwdata_nxt = idx_q[0] ? pl_q.p0 : pl_q.p1;
                  state_nxt  = SETUP;
               end
            end else if (timer_expired) begin
               err_nxt   = 1'b1;
               tmo_nxt   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      psel_nxt    = (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable_nxt = (state_nxt == ACCESS);
      busy_nxt    = (state_nxt != IDLE);
      done_nxt    = (state_nxt == DONE);
   end

   assign pwrite  = psel;
   assign timeout = tmo_q;

endmodule

// File: tb/tb_apb_payload_writer.sv
// Randomized bench for apb_payload_writer with a burst-level reference model.
module tb_apb_payload_writer;

   localparam int unsigned BASE  = 0;
   localparam int unsigned STEP  = 1;
   localparam bit          ABORT = 1'b1;
   localparam int unsigned TMO   = 16;

   logic       pclk = 1'b0;
   logic       preset_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] payload_0 = '0;
   logic [7:0] payload_1 = '0;
   logic [4:0] data_size = '0;
   logic       pready = 1'b0;
   logic       pslverr = 1'b0;
   logic       busy, done, err, timeout, psel, penable, pwrite;
   logic [7:0] paddr, pwdata;

   int vectors = 0;
   int miscompares = 0;

   // Slave behaviour per byte: ACCESS wait states and error response.
   int waits[32];
   bit errs[32];

   logic [7:0] exp_a[$], exp_d[$], obs_a[$], obs_d[$];
   int         exp_done, obs_done, obs_viol;
   logic       exp_err, exp_tmo, obs_err, obs_tmo;
   string      obs_viol_name;

   apb_payload_writer #(
      .ADDR_W       (8),
      .BASE_ADDR    (BASE),
      .ADDR_STEP    (STEP),
      .ABORT_ON_ERR (ABORT),
      .TIMEOUT_CYC  (TMO)
   ) dut (
      .pclk      (pclk),
      .preset_n  (preset_n),
      .start     (start),
      .payload_0 (payload_0),
      .payload_1 (payload_1),
      .data_size (data_size),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .timeout   (timeout),
      .paddr     (paddr),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   always #5 pclk = ~pclk;

   function automatic void clear_cfg();
      for (int i = 0; i < 32; i++) begin
         waits[i] = 0;
         errs[i]  = 1'b0;
      end
   endfunction

   function automatic void flag(input string name);
      obs_viol++;
      obs_viol_name = name;
   endfunction

   // Burst outcome from the rules: list of writes, done cycle, final flags.
   function automatic void ref_burst(input int size, input logic [7:0] p0, input logic [7:0] p1);
      exp_a.delete();
      exp_d.delete();
      exp_done = 1;
      exp_err  = 1'b0;
      exp_tmo  = 1'b0;
      for (int b = 0; b < size; b++) begin
`ifdef APB_WR_TIMEOUT_EN
         if (waits[b] >= int'(TMO)) begin
            exp_done += 1 + int'(TMO);
            exp_err  = 1'b1;
            exp_tmo  = 1'b1;
            break;
         end
`endif
         exp_a.push_back(8'(BASE + b * STEP));
         exp_d.push_back((b % 2 == 0) ? p0 : p1);
         exp_done += 2 + waits[b];
         if (errs[b]) exp_err = 1'b1;
         if (errs[b] && ABORT) break;
      end
   endfunction

   // Launch one burst, play the APB slave, record what the DUT did.
   task automatic run_burst(input int size, input logic [7:0] p0, input logic [7:0] p1);
      int cyc, sb, wcnt;
      logic [7:0] ha, hd;
      bit fin;
      cyc = 0; sb = 0; wcnt = 0; ha = '0; hd = '0; fin = 1'b0;
      obs_a.delete(); obs_d.delete();
      obs_viol = 0; obs_viol_name = "none"; obs_err = 1'bx; obs_tmo = 1'bx;
      start = 1'b1; payload_0 = p0; payload_1 = p1; data_size = 5'(size);
      while (!fin && cyc < 600) begin
         @(posedge pclk); #1; cyc++;
         start     = 1'($urandom_range(0, 1));
         payload_0 = 8'($urandom);
         payload_1 = 8'($urandom);
         data_size = 5'($urandom);
         pready    = 1'($urandom_range(0, 1));
         pslverr   = 1'($urandom_range(0, 1));
         if (busy !== 1'b1) flag("busy_low");
         if (pwrite !== psel) flag("pwrite_ne_psel");
         if (cyc == 1 && err !== 1'b0) flag("err_not_cleared");
         if (psel === 1'b1 && penable === 1'b0) begin
            ha = paddr; hd = pwdata;
         end
         if (psel === 1'b1 && penable === 1'b1) begin
            if (paddr !== ha || pwdata !== hd) flag("access_unstable");
            if (wcnt < waits[sb]) begin
               pready = 1'b0;
               wcnt++;
            end else begin
               pready  = 1'b1;
               pslverr = errs[sb];
               obs_a.push_back(paddr);
               obs_d.push_back(pwdata);
               wcnt = 0;
               if (sb < 31) sb++;
            end
         end
         if (done === 1'b1) begin
            fin = 1'b1;
            if (psel !== 1'b0) flag("psel_in_done");
            obs_err = err;
            obs_tmo = timeout;
         end else if (psel !== 1'b1) begin
            flag("psel_gap");
         end
      end
      obs_done = cyc;
      // start held high through DONE must not relaunch.
      start = 1'b1;
      @(posedge pclk); #1;
      if (busy !== 1'b0 || psel !== 1'b0 || done !== 1'b0) flag("restart_from_done");
      if (err !== obs_err) flag("err_not_sticky");
      start = 1'b0; pready = 1'b0; pslverr = 1'b0;
   endtask

   task automatic test_reset();
      start = 1'b1; data_size = 5'd3;
      repeat (2) @(posedge pclk);
      #1;
      vectors++;
      if ({busy, done, err, timeout, psel, penable, pwrite, paddr, pwdata} !== 23'h0) begin
         miscompares++;
         $display("FAIL reset_outputs got %h want 0", {busy, done, err, timeout, psel, penable, pwrite, paddr, pwdata});
      end
      start = 1'b0; preset_n = 1'b1;
      @(posedge pclk); #1;
      vectors++;
      if (busy !== 1'b0 || psel !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_idle got busy=%b psel=%b want 0 0", busy, psel);
      end
   endtask

   task automatic test_basic();
      clear_cfg();
      exp_a = '{8'h00, 8'h01, 8'h02};
      exp_d = '{8'hA5, 8'h3C, 8'hA5};
      exp_done = 7; exp_err = 1'b0; exp_tmo = 1'b0;
      run_burst(3, 8'hA5, 8'h3C);
      vectors++; if (obs_done != exp_done) begin miscompares++; $display("FAIL basic_done_cycle got %0d want %0d", obs_done, exp_done); end
      vectors++; if (obs_a.size() != exp_a.size()) begin miscompares++; $display("FAIL basic_xfer_count got %0d want %0d", obs_a.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
         vectors++;
         if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
            miscompares++;
            $display("FAIL basic_xfer%0d got (%h,%h) want (%h,%h)", i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
         end
      end
      vectors++; if (obs_err !== exp_err) begin miscompares++; $display("FAIL basic_err got %b want %b", obs_err, exp_err); end
      vectors++; if (obs_viol != 0) begin miscompares++; $display("FAIL basic_protocol got %0d (%s) want 0", obs_viol, obs_viol_name); end
   endtask

   task automatic test_zero_size();
      clear_cfg();
      run_burst(0, 8'h77, 8'h88);
      vectors++; if (obs_done != 1) begin miscompares++; $display("FAIL zero_done_cycle got %0d want 1", obs_done); end
      vectors++; if (obs_a.size() != 0) begin miscompares++; $display("FAIL zero_xfer_count got %0d want 0", obs_a.size()); end
      vectors++; if (obs_viol != 0) begin miscompares++; $display("FAIL zero_protocol got %0d (%s) want 0", obs_viol, obs_viol_name); end
   endtask

   task automatic test_wait_states();
      clear_cfg();
      waits[0] = 3;
      run_burst(2, 8'h12, 8'h34);
      vectors++; if (obs_done != 8) begin miscompares++; $display("FAIL wait_done_cycle got %0d want 8", obs_done); end
      vectors++; if (obs_a.size() != 2) begin miscompares++; $display("FAIL wait_xfer_count got %0d want 2", obs_a.size()); end
      if (obs_a.size() == 2) begin
         vectors++;
         if ({obs_a[0], obs_d[0], obs_a[1], obs_d[1]} !== 32'h00_12_01_34) begin
            miscompares++;
            $display("FAIL wait_xfers got %h want 00120134", {obs_a[0], obs_d[0], obs_a[1], obs_d[1]});
         end
      end
      vectors++; if (obs_viol != 0) begin miscompares++; $display("FAIL wait_protocol got %0d (%s) want 0", obs_viol, obs_viol_name); end
   endtask

   task automatic test_abort_on_error();
      clear_cfg();
      errs[1] = 1'b1;
      run_burst(4, 8'h5A, 8'hC3);
      vectors++; if (obs_a.size() != 2) begin miscompares++; $display("FAIL abort_xfer_count got %0d want 2", obs_a.size()); end
      vectors++; if (obs_done != 5) begin miscompares++; $display("FAIL abort_done_cycle got %0d want 5", obs_done); end
      vectors++; if (obs_err !== 1'b1) begin miscompares++; $display("FAIL abort_err got %b want 1", obs_err); end
      vectors++; if (obs_viol != 0) begin miscompares++; $display("FAIL abort_protocol got %0d (%s) want 0", obs_viol, obs_viol_name); end
      // The next accepted start clears the sticky error.
      clear_cfg();
      run_burst(1, 8'h9E, 8'h00);
      vectors++; if (obs_err !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", obs_err); end
      vectors++; if (obs_done != 3) begin miscompares++; $display("FAIL err_clear_done got %0d want 3", obs_done); end
      vectors++; if (obs_viol != 0) begin miscompares++; $display("FAIL err_clear_protocol got %0d (%s) want 0", obs_viol, obs_viol_name); end
   endtask

   task automatic test_random();
      int size;
      logic [7:0] p0, p1;
      for (int n = 0; n < 25; n++) begin
         size = (n == 0) ? 31 : (n == 1) ? 1 : $urandom_range(0, 31);
         p0 = 8'($urandom);
         p1 = 8'($urandom);
         for (int i = 0; i < 32; i++) begin
            waits[i] = $urandom_range(0, 3);
            errs[i]  = ($urandom_range(0, 7) == 0);
         end
         ref_burst(size, p0, p1);
         run_burst(size, p0, p1);
         vectors++; if (obs_done != exp_done) begin miscompares++; $display("FAIL rand%0d_done_cycle got %0d want %0d", n, obs_done, exp_done); end
         vectors++; if (obs_a.size() != exp_a.size()) begin miscompares++; $display("FAIL rand%0d_xfer_count got %0d want %0d", n, obs_a.size(), exp_a.size()); end
         for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            vectors++;
            if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
               miscompares++;
               $display("FAIL rand%0d_xfer%0d got (%h,%h) want (%h,%h)", n, i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
            end
         end
         vectors++; if (obs_err !== exp_err) begin miscompares++; $display("FAIL rand%0d_err got %b want %b", n, obs_err, exp_err); end
         vectors++; if (obs_tmo !== exp_tmo) begin miscompares++; $display("FAIL rand%0d_timeout got %b want %b", n, obs_tmo, exp_tmo); end
         vectors++; if (obs_viol != 0) begin miscompares++; $display("FAIL rand%0d_protocol got %0d (%s) want 0", n, obs_viol, obs_viol_name); end
      end
   endtask

   task automatic test_long_wait();
      clear_cfg();
`ifdef APB_WR_TIMEOUT_EN
      waits[0] = 1000;
`else
      waits[0] = 40;
`endif
      ref_burst(2, 8'hE1, 8'h1E);
      run_burst(2, 8'hE1, 8'h1E);
      vectors++; if (obs_done != exp_done) begin miscompares++; $display("FAIL longwait_done_cycle got %0d want %0d", obs_done, exp_done); end
      vectors++; if (obs_a.size() != exp_a.size()) begin miscompares++; $display("FAIL longwait_xfer_count got %0d want %0d", obs_a.size(), exp_a.size()); end
      vectors++; if (obs_tmo !== exp_tmo) begin miscompares++; $display("FAIL longwait_timeout got %b want %b", obs_tmo, exp_tmo); end
      vectors++; if (obs_err !== exp_err) begin miscompares++; $display("FAIL longwait_err got %b want %b", obs_err, exp_err); end
      vectors++; if (obs_viol != 0) begin miscompares++; $display("FAIL longwait_protocol got %0d (%s) want 0", obs_viol, obs_viol_name); end
   endtask

   task automatic test_reset_mid_access();
      start = 1'b1; payload_0 = 8'h11; payload_1 = 8'h22; data_size = 5'd4;
      pready = 1'b0; pslverr = 1'b0;
      @(posedge pclk); #1; start = 1'b0;   // SETUP byte 0
      @(posedge pclk); #1; pready = 1'b1;  // ACCESS byte 0 completes
      @(posedge pclk); #1; pready = 1'b0;  // SETUP byte 1
      @(posedge pclk); #1;                 // ACCESS byte 1, waiting
      vectors++;
      if ({psel, penable, paddr, pwdata} !== {1'b1, 1'b1, 8'h01, 8'h22}) begin
         miscompares++;
         $display("FAIL rst_pre_access got %h want 30122", {psel, penable, paddr, pwdata});
      end
      #2 preset_n = 1'b0;
      #1;
      vectors++;
      if ({psel, penable, busy, done, err, timeout} !== 6'b0) begin
         miscompares++;
         $display("FAIL rst_async_drop got %b want 000000", {psel, penable, busy, done, err, timeout});
      end
      vectors++;
      if ({paddr, pwdata} !== 16'h0) begin
         miscompares++;
         $display("FAIL rst_async_bus got %h want 0000", {paddr, pwdata});
      end
      @(posedge pclk); #1;
      preset_n = 1'b1; pready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge pclk); #1;
         vectors++;
         if (psel !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_resume c%0d got psel=%b busy=%b done=%b want 0 0 0", c, psel, busy, done);
         end
      end
      pready = 1'b0;
   endtask

   initial begin
      clear_cfg();
      test_reset();
      test_basic();
      test_zero_size();
      test_wait_states();
      test_abort_on_error();
      test_random();
      test_long_wait();
      test_reset_mid_access();
      test_basic();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/apb_payload_writer.md
Name: apb_payload_writer

Overview:
- Sequencer that delivers the latched payload register set (payload_0, payload_1, data_size) to an APB peripheral as a burst of single-byte APB write transfers.
- Sits downstream of the AHB-side payload registers, in the pclk domain. Acts as APB requester: owns psel/penable/paddr/pwdata and sequences SETUP/ACCESS phases with wait states and error handling.

Parameters:
- ADDR_W, 8, APB address width.
- BASE_ADDR, 0, paddr of byte 0.
- ADDR_STEP, 1, paddr increment per byte.
- ABORT_ON_ERR, 1, 1 = stop burst on first pslverr; 0 = record error and continue.
- TIMEOUT_CYC, 16, max ACCESS-phase cycles before timeout (only with APB_WR_TIMEOUT_EN).

Ports:
- pclk  in  1  clock
- preset_n  in  1  reset, asynchronous, active-low
- start  in  1  request to launch a burst; sampled only in IDLE
- payload_0  in  8  data for even byte indices
- payload_1  in  8  data for odd byte indices
- data_size  in  5  number of bytes to send, 0..31
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error (pslverr or timeout); cleared on next accepted start
- timeout  out  1  sticky timeout flag; cleared on next accepted start
- paddr  out  ADDR_W  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB write strobe; equals psel
- pwdata  out  8  APB write data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error, valid when psel & penable & pready

Behaviour:
- Reset: all outputs 0 and state IDLE immediately on preset_n low, including mid-transfer. psel and penable drop asynchronously. No transfer resumes after reset.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: on start, latch payload_0, payload_1, data_size; set byte index i=0; clear err and timeout.
  - data_size!=0: go to SETUP.
  - data_size==0: go to DONE with no APB transfer.
- SETUP (1 cycle): psel=1, penable=0, paddr=BASE_ADDR+i*ADDR_STEP (truncated to ADDR_W, wraps), pwdata = payload_0 if i even else payload_1. Go to ACCESS.
- ACCESS: psel=1, penable=1. paddr and pwdata are held stable.
  - pready=0: stay in ACCESS.
  - pready=1: the transfer completes. If pslverr=1, set err. Then:
    - if pslverr and ABORT_ON_ERR: go to DONE;
    - else if i==latched size-1: go to DONE;
    - else i++ and go to SETUP. There is no idle cycle between transfers.
- DONE: done=1 for exactly one cycle, psel=0; go to IDLE.
- busy is 1 in SETUP/ACCESS/DONE and 0 in IDLE.
- Latency with zero wait states: start seen in cycle 0, first SETUP in cycle 1, N bytes take 2N cycles, done asserts in cycle 2N+1.
- Each wait state adds 1 cycle.
- start while busy: ignored, no queueing. Payload input changes while busy do not affect the burst in flight.
- start high in the DONE cycle: ignored. start must be high in IDLE to be accepted.

Optional Feature:
- Macro: APB_WR_TIMEOUT_EN.
- Defined: a counter runs in ACCESS and resets on entry to each SETUP. If TIMEOUT_CYC ACCESS cycles elapse without pready, then set timeout=1 and err=1, drop psel/penable next cycle, and go to DONE regardless of ABORT_ON_ERR.
- Undefined: ACCESS waits indefinitely; timeout output tied 0; no counter logic.

Decomposition:
- Package apb_payload_pkg: state enum (IDLE, SETUP, ACCESS, DONE), DATA_W=8, SIZE_W=5, default ADDR_W.
- Optional sub-module apb_wr_timer: timeout counter (enable, clear, expired). Instantiated only under APB_WR_TIMEOUT_EN.

Test Plan:
- Reset then start, data_size=3, payload_0=0xA5, payload_1=0x3C, pready=1 -> writes (0x00,A5),(0x01,3C),(0x02,A5); done in cycle 7; err=0.
- data_size=0 + start -> no psel; done pulse in cycle 1; busy high 1 cycle.
- data_size=2, pready low 3 cycles on byte 0 -> paddr/pwdata stable through ACCESS; done in cycle 8.
- ABORT_ON_ERR=1, data_size=4, pslverr on byte 1 -> only 2 transfers, err=1, done pulse; next start clears err.
- preset_n low during ACCESS of byte 1 -> psel/penable/busy 0 immediately; after release, IDLE, no resumed transfer.
- With APB_WR_TIMEOUT_EN, TIMEOUT_CYC=4, pready held 0 -> timeout=1, err=1, done after 4 ACCESS cycles; without macro, psel held until pready.
